// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular in-order commit buffer with CDB forwarding and mispredict flush
module reorder_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int ROB_WIDTH  = 4,
  parameter int ROB_SIZE   = 1 << ROB_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  DP2ROB_en,
  input  logic [1:0]            DP2ROB_type,
  input  logic [REG_WIDTH-1:0]  DP2ROB_rd,
  input  logic [ADDR_WIDTH-1:0] DP2ROB_pred_pc,
  input  logic                  DP2ROB_ready,
  input  logic [31:0]           DP2ROB_value,
  output logic                  ROB2DP_full,
  output logic [ROB_WIDTH-1:0]  ROB2DP_tail_index,
  input  logic [ROB_WIDTH-1:0]  DP2ROB_query1_index,
  input  logic [ROB_WIDTH-1:0]  DP2ROB_query2_index,
  output logic                  ROB2DP_query1_ready,
  output logic                  ROB2DP_query2_ready,
  output logic [31:0]           ROB2DP_query1_value,
  output logic [31:0]           ROB2DP_query2_value,
  input  logic                  CDB2ROB_RS_en,
  input  logic [ROB_WIDTH-1:0]  CDB2ROB_RS_ROB_index,
  input  logic [31:0]           CDB2ROB_RS_value,
  input  logic [ADDR_WIDTH-1:0] CDB2ROB_RS_next_pc,
  input  logic                  CDB2ROB_LSB_en,
  input  logic [ROB_WIDTH-1:0]  CDB2ROB_LSB_ROB_index,
  input  logic [31:0]           CDB2ROB_LSB_value,
  output logic                  ROB2RF_en,
  output logic [REG_WIDTH-1:0]  ROB2RF_rd,
  output logic [31:0]           ROB2RF_value,
  output logic [ROB_WIDTH-1:0]  ROB2RF_ROB_index,
  output logic                  ROB2LSB_store_en,
  output logic [ROB_WIDTH-1:0]  ROB2LSB_ROB_index,
  output logic                  ROB2ALL_flush,
  output logic [ADDR_WIDTH-1:0] ROB2IF_new_pc
);
  localparam int CW = ROB_WIDTH + 1;
  logic [ROB_SIZE-1:0]   busy_q, ready_q, busy_d, ready_d;
  logic [1:0]            type_q    [ROB_SIZE];
  logic [REG_WIDTH-1:0]  rd_q      [ROB_SIZE];
  logic [ADDR_WIDTH-1:0] pred_pc_q [ROB_SIZE];
  logic [ADDR_WIDTH-1:0] next_pc_q [ROB_SIZE];
  logic [31:0]           value_q   [ROB_SIZE];
  logic [ROB_WIDTH-1:0]  head_q, tail_q, head_d, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rf_en_q, st_en_q, flush_q;
  logic [REG_WIDTH-1:0]  rf_rd_q;
  logic [31:0]           rf_value_q;
  logic [ROB_WIDTH-1:0]  rf_idx_q, st_idx_q;
  logic [ADDR_WIDTH-1:0] new_pc_q;
  logic full, alloc, commit, is_store, is_branch, mispredict, rs_wb, lsb_wb;
  logic q1_rs, q1_lsb, q2_rs, q2_lsb;
  assign full       = count_q == CW'(ROB_SIZE);
  assign alloc      = DP2ROB_en && !full;
  assign commit     = count_q != '0 && busy_q[head_q] && ready_q[head_q];
  assign is_store   = type_q[head_q] == 2'b01;
  assign is_branch  = type_q[head_q] == 2'b10;
  assign mispredict = commit && is_branch && next_pc_q[head_q] != pred_pc_q[head_q];
  assign rs_wb      = CDB2ROB_RS_en && busy_q[CDB2ROB_RS_ROB_index];
  assign lsb_wb     = CDB2ROB_LSB_en && busy_q[CDB2ROB_LSB_ROB_index];
  assign head_d     = head_q + ROB_WIDTH'(commit);
  assign tail_d     = tail_q + ROB_WIDTH'(alloc);
  assign count_d    = count_q + CW'(alloc) - CW'(commit);
  // Commit clears last so a retiring head never stays busy
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    if (alloc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = DP2ROB_ready;
    end
    if (rs_wb) ready_d[CDB2ROB_RS_ROB_index] = 1'b1;
    if (lsb_wb) ready_d[CDB2ROB_LSB_ROB_index] = 1'b1;
    if (commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      ready_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_en_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_value_q <= '0;
      rf_idx_q   <= '0;
      st_en_q    <= 1'b0;
      st_idx_q   <= '0;
      flush_q    <= 1'b0;
      new_pc_q   <= '0;
    end else if (!rdy_in) begin
      rf_en_q <= 1'b0;
      st_en_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      rf_en_q    <= commit && !is_store && rd_q[head_q] != '0;
      rf_rd_q    <= rd_q[head_q];
      rf_value_q <= value_q[head_q];
      rf_idx_q   <= head_q;
      st_en_q    <= commit && is_store;
      st_idx_q   <= head_q;
      flush_q    <= mispredict;
      new_pc_q   <= next_pc_q[head_q];
      if (mispredict) begin
        busy_q  <= '0;
        ready_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        busy_q  <= busy_d;
        ready_q <= ready_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end
  end
  // Payload needs no reset: busy/ready gate every use of it; LSB write lands last so it wins
  always_ff @(posedge clk_in) begin
    if (rdy_in && !mispredict) begin
      if (alloc) begin
        type_q[tail_q]    <= DP2ROB_type;
        rd_q[tail_q]      <= DP2ROB_rd;
        pred_pc_q[tail_q] <= DP2ROB_pred_pc;
        value_q[tail_q]   <= DP2ROB_value;
      end
      if (rs_wb) begin
        value_q[CDB2ROB_RS_ROB_index]   <= CDB2ROB_RS_value;
        next_pc_q[CDB2ROB_RS_ROB_index] <= CDB2ROB_RS_next_pc;
      end
      if (lsb_wb) value_q[CDB2ROB_LSB_ROB_index] <= CDB2ROB_LSB_value;
    end
  end
  assign q1_rs  = CDB2ROB_RS_en && CDB2ROB_RS_ROB_index == DP2ROB_query1_index;
  assign q1_lsb = CDB2ROB_LSB_en && CDB2ROB_LSB_ROB_index == DP2ROB_query1_index;
  assign q2_rs  = CDB2ROB_RS_en && CDB2ROB_RS_ROB_index == DP2ROB_query2_index;
  assign q2_lsb = CDB2ROB_LSB_en && CDB2ROB_LSB_ROB_index == DP2ROB_query2_index;
  assign ROB2DP_query1_ready = ready_q[DP2ROB_query1_index] || q1_rs || q1_lsb;
  assign ROB2DP_query2_ready = ready_q[DP2ROB_query2_index] || q2_rs || q2_lsb;
  assign ROB2DP_query1_value = ready_q[DP2ROB_query1_index] ? value_q[DP2ROB_query1_index] :
                               q1_rs ? CDB2ROB_RS_value : q1_lsb ? CDB2ROB_LSB_value : '0;
  assign ROB2DP_query2_value = ready_q[DP2ROB_query2_index] ? value_q[DP2ROB_query2_index] :
                               q2_rs ? CDB2ROB_RS_value : q2_lsb ? CDB2ROB_LSB_value : '0;
  assign ROB2DP_full       = full;
  assign ROB2DP_tail_index = tail_q;
  assign ROB2RF_en         = rf_en_q;
  assign ROB2RF_rd         = rf_rd_q;
  assign ROB2RF_value      = rf_value_q;
  assign ROB2RF_ROB_index  = rf_idx_q;
  assign ROB2LSB_store_en  = st_en_q;
  assign ROB2LSB_ROB_index = st_idx_q;
  assign ROB2ALL_flush     = flush_q;
  assign ROB2IF_new_pc     = new_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic        DP2ROB_en = 1'b0, DP2ROB_ready = 1'b0;
  logic [1:0]  DP2ROB_type = '0;
  logic [4:0]  DP2ROB_rd = '0;
  logic [31:0] DP2ROB_pred_pc = '0, DP2ROB_value = '0;
  logic        ROB2DP_full;
  logic [3:0]  ROB2DP_tail_index;
  logic [3:0]  DP2ROB_query1_index = '0, DP2ROB_query2_index = '0;
  logic        ROB2DP_query1_ready, ROB2DP_query2_ready;
  logic [31:0] ROB2DP_query1_value, ROB2DP_query2_value;
  logic        CDB2ROB_RS_en = 1'b0, CDB2ROB_LSB_en = 1'b0;
  logic [3:0]  CDB2ROB_RS_ROB_index = '0, CDB2ROB_LSB_ROB_index = '0;
  logic [31:0] CDB2ROB_RS_value = '0, CDB2ROB_RS_next_pc = '0, CDB2ROB_LSB_value = '0;
  logic        ROB2RF_en, ROB2LSB_store_en, ROB2ALL_flush;
  logic [4:0]  ROB2RF_rd;
  logic [31:0] ROB2RF_value, ROB2IF_new_pc;
  logic [3:0]  ROB2RF_ROB_index, ROB2LSB_ROB_index;
  int errors = 0, checks = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .DP2ROB_en(DP2ROB_en), .DP2ROB_type(DP2ROB_type), .DP2ROB_rd(DP2ROB_rd),
    .DP2ROB_pred_pc(DP2ROB_pred_pc), .DP2ROB_ready(DP2ROB_ready), .DP2ROB_value(DP2ROB_value),
    .ROB2DP_full(ROB2DP_full), .ROB2DP_tail_index(ROB2DP_tail_index),
    .DP2ROB_query1_index(DP2ROB_query1_index), .DP2ROB_query2_index(DP2ROB_query2_index),
    .ROB2DP_query1_ready(ROB2DP_query1_ready), .ROB2DP_query2_ready(ROB2DP_query2_ready),
    .ROB2DP_query1_value(ROB2DP_query1_value), .ROB2DP_query2_value(ROB2DP_query2_value),
    .CDB2ROB_RS_en(CDB2ROB_RS_en), .CDB2ROB_RS_ROB_index(CDB2ROB_RS_ROB_index),
    .CDB2ROB_RS_value(CDB2ROB_RS_value), .CDB2ROB_RS_next_pc(CDB2ROB_RS_next_pc),
    .CDB2ROB_LSB_en(CDB2ROB_LSB_en), .CDB2ROB_LSB_ROB_index(CDB2ROB_LSB_ROB_index),
    .CDB2ROB_LSB_value(CDB2ROB_LSB_value),
    .ROB2RF_en(ROB2RF_en), .ROB2RF_rd(ROB2RF_rd), .ROB2RF_value(ROB2RF_value),
    .ROB2RF_ROB_index(ROB2RF_ROB_index), .ROB2LSB_store_en(ROB2LSB_store_en),
    .ROB2LSB_ROB_index(ROB2LSB_ROB_index), .ROB2ALL_flush(ROB2ALL_flush),
    .ROB2IF_new_pc(ROB2IF_new_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic rdy, input logic [31:0] v);
    DP2ROB_en = 1'b1; DP2ROB_type = t; DP2ROB_rd = rd;
    DP2ROB_pred_pc = pc; DP2ROB_ready = rdy; DP2ROB_value = v;
    step;
    DP2ROB_en = 1'b0;
  endtask

  task automatic rs_wb(input logic [3:0] idx, input logic [31:0] v, input logic [31:0] npc);
    CDB2ROB_RS_en = 1'b1; CDB2ROB_RS_ROB_index = idx;
    CDB2ROB_RS_value = v; CDB2ROB_RS_next_pc = npc;
    step;
    CDB2ROB_RS_en = 1'b0;
  endtask

  task automatic lsb_wb(input logic [3:0] idx, input logic [31:0] v);
    CDB2ROB_LSB_en = 1'b1; CDB2ROB_LSB_ROB_index = idx; CDB2ROB_LSB_value = v;
    step;
    CDB2ROB_LSB_en = 1'b0;
  endtask

  task automatic do_reset;
    rst_in = 1'b1;
    step;
    step;
    rst_in = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset;
    chk("rst_rf_en", ROB2RF_en, 0);
    chk("rst_rf_rd", ROB2RF_rd, 0);
    chk("rst_store", ROB2LSB_store_en, 0);
    chk("rst_flush", ROB2ALL_flush, 0);
    chk("rst_new_pc", ROB2IF_new_pc, 0);
    chk("rst_full", ROB2DP_full, 0);
    chk("rst_tail", ROB2DP_tail_index, 0);
    chk("rst_q1_ready", ROB2DP_query1_ready, 0);
    // in-order commit with out-of-order writeback
    alloc(2'b00, 5'd1, 0, 1'b0, 0);
    alloc(2'b00, 5'd2, 0, 1'b0, 0);
    alloc(2'b00, 5'd3, 0, 1'b0, 0);
    chk("A_tail3", ROB2DP_tail_index, 3);
    rs_wb(4'd1, 32'h11, 0);
    step;
    chk("A_no_ooo", ROB2RF_en, 0);
    rs_wb(4'd0, 32'h10, 0);
    chk("A_wb_to_pulse_gap", ROB2RF_en, 0);
    step;
    chk("A_c0_en", ROB2RF_en, 1);
    chk("A_c0_rd", ROB2RF_rd, 1);
    chk("A_c0_val", ROB2RF_value, 32'h10);
    chk("A_c0_idx", ROB2RF_ROB_index, 0);
    step;
    chk("A_c1_en", ROB2RF_en, 1);
    chk("A_c1_rd", ROB2RF_rd, 2);
    chk("A_c1_val", ROB2RF_value, 32'h11);
    chk("A_c1_idx", ROB2RF_ROB_index, 1);
    rs_wb(4'd2, 32'h12, 0);
    chk("A_wait2", ROB2RF_en, 0);
    step;
    chk("A_c2_en", ROB2RF_en, 1);
    chk("A_c2_rd", ROB2RF_rd, 3);
    chk("A_c2_val", ROB2RF_value, 32'h12);
    step;
    chk("A_pulse_end", ROB2RF_en, 0);
    // query forwarding
    do_reset;
    for (int i = 0; i < 6; i++) alloc(2'b00, 5'(i + 1), 0, 1'b0, 0);
    DP2ROB_query1_index = 4'd5; DP2ROB_query2_index = 4'd4;
    CDB2ROB_LSB_en = 1'b1; CDB2ROB_LSB_ROB_index = 4'd5; CDB2ROB_LSB_value = 32'hDEADBEEF;
    #1;
    chk("B_fwd_lsb_rdy", ROB2DP_query1_ready, 1);
    chk("B_fwd_lsb_val", ROB2DP_query1_value, 32'hDEADBEEF);
    chk("B_q2_rdy", ROB2DP_query2_ready, 0);
    chk("B_q2_val", ROB2DP_query2_value, 0);
    step;
    CDB2ROB_LSB_en = 1'b0;
    #1;
    chk("B_entry_rdy", ROB2DP_query1_ready, 1);
    chk("B_entry_val", ROB2DP_query1_value, 32'hDEADBEEF);
    CDB2ROB_RS_en = 1'b1; CDB2ROB_RS_ROB_index = 4'd4; CDB2ROB_RS_value = 32'h44;
    #1;
    chk("B_fwd_rs_rdy", ROB2DP_query2_ready, 1);
    chk("B_fwd_rs_val", ROB2DP_query2_value, 32'h44);
    CDB2ROB_RS_ROB_index = 4'd5; CDB2ROB_RS_value = 32'h1234;
    #1;
    chk("B_entry_over_rs", ROB2DP_query1_value, 32'hDEADBEEF);
    CDB2ROB_RS_en = 1'b0;
    #1;
    chk("B_q2_unready", ROB2DP_query2_ready, 0);
    lsb_wb(4'd9, 32'h99);
    DP2ROB_query1_index = 4'd9;
    #1;
    chk("B_nonbusy_wb", ROB2DP_query1_ready, 0);
    // full and wrap
    do_reset;
    for (int i = 0; i < 16; i++) alloc(2'b00, 5'd7, 0, 1'b0, 0);
    chk("C_full", ROB2DP_full, 1);
    chk("C_tail_wrap", ROB2DP_tail_index, 0);
    alloc(2'b00, 5'd8, 0, 1'b1, 32'hAAAA);
    DP2ROB_query1_index = 4'd0;
    #1;
    chk("C_17th_full", ROB2DP_full, 1);
    chk("C_17th_tail", ROB2DP_tail_index, 0);
    chk("C_17th_no_write", ROB2DP_query1_ready, 0);
    rs_wb(4'd0, 32'h77, 0);
    DP2ROB_en = 1'b1; DP2ROB_type = 2'b00; DP2ROB_rd = 5'd9; DP2ROB_ready = 1'b0;
    step;
    chk("C_commit_en", ROB2RF_en, 1);
    chk("C_commit_val", ROB2RF_value, 32'h77);
    chk("C_freed_full", ROB2DP_full, 0);
    chk("C_blocked_tail", ROB2DP_tail_index, 0);
    step;
    DP2ROB_en = 1'b0;
    chk("C_refull", ROB2DP_full, 1);
    chk("C_refill_tail", ROB2DP_tail_index, 1);
    // mispredict flush
    do_reset;
    alloc(2'b10, 5'd1, 32'h1004, 1'b0, 0);
    alloc(2'b00, 5'd2, 0, 1'b1, 32'h22);
    alloc(2'b00, 5'd3, 0, 1'b0, 0);
    rs_wb(4'd0, 32'h1004, 32'h2000);
    DP2ROB_en = 1'b1; DP2ROB_type = 2'b00; DP2ROB_rd = 5'd9; DP2ROB_ready = 1'b1;
    step;
    DP2ROB_en = 1'b0;
    chk("D_flush", ROB2ALL_flush, 1);
    chk("D_new_pc", ROB2IF_new_pc, 32'h2000);
    chk("D_link_en", ROB2RF_en, 1);
    chk("D_link_rd", ROB2RF_rd, 1);
    chk("D_link_val", ROB2RF_value, 32'h1004);
    chk("D_tail0", ROB2DP_tail_index, 0);
    chk("D_not_full", ROB2DP_full, 0);
    step;
    chk("D_flush_1cyc", ROB2ALL_flush, 0);
    chk("D_young_no_commit", ROB2RF_en, 0);
    step;
    chk("D_young_no_commit2", ROB2RF_en, 0);
    DP2ROB_query1_index = 4'd1;
    #1;
    chk("D_entry_cleared", ROB2DP_query1_ready, 0);
    // rd==0, store, correctly predicted branch
    alloc(2'b00, 5'd0, 0, 1'b1, 32'h5);
    alloc(2'b01, 5'd0, 0, 1'b0, 0);
    chk("E_rd0_no_rf", ROB2RF_en, 0);
    chk("E_rd0_no_st", ROB2LSB_store_en, 0);
    alloc(2'b10, 5'd0, 32'h3000, 1'b0, 0);
    lsb_wb(4'd1, 0);
    step;
    chk("E_store_en", ROB2LSB_store_en, 1);
    chk("E_store_idx", ROB2LSB_ROB_index, 1);
    chk("E_store_no_rf", ROB2RF_en, 0);
    rs_wb(4'd2, 0, 32'h3000);
    step;
    chk("E_br_ok_no_flush", ROB2ALL_flush, 0);
    chk("E_br_rd0_no_rf", ROB2RF_en, 0);
    chk("E_tail3", ROB2DP_tail_index, 3);
    // asynchronous reset mid-stream, then rdy_in freeze
    alloc(2'b00, 5'd4, 0, 1'b1, 32'h44);
    step;
    chk("F_pre_rst_en", ROB2RF_en, 1);
    chk("F_pre_rst_idx", ROB2RF_ROB_index, 3);
    #2;
    rst_in = 1'b1;
    #1;
    chk("F_async_en", ROB2RF_en, 0);
    chk("F_async_rd", ROB2RF_rd, 0);
    chk("F_async_val", ROB2RF_value, 0);
    chk("F_async_tail", ROB2DP_tail_index, 0);
    rst_in = 1'b0;
    alloc(2'b00, 5'd5, 0, 1'b0, 0);
    chk("F_resume_tail", ROB2DP_tail_index, 1);
    rdy_in = 1'b0;
    alloc(2'b00, 5'd6, 0, 1'b0, 0);
    rdy_in = 1'b1;
    chk("F_rdy_freeze", ROB2DP_tail_index, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
